hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline (F/D/E/M/W). It produces the E-stage forwarding selects, the load-use stall and the branch/jump flush. A data-memory wait state machine freezes the pipeline while the data memory is not ready. It also keeps a sticky memory-timeout flag and two performance counters. It sits beside the stage registers and drives their stall/flush controls.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/mem_wait_fsm.sv | 77 +++++++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard unit.
// Forward selects, load result tag, memory FSM states.
package pipeline_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } memState_t;

  // Youngest in-flight writer wins; x0 is never forwarded.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic [4:0] rdM,
    input logic       wrM,
    input logic [4:0] rdW,
    input logic       wrW
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (wrM && (rdM != 5'd0) && (rdM == rs))
      sel = FWD_M;
    else if (wrW && (rdW != 5'd0) && (rdW == rs))
      sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker: freezes the pipe while
// memory is busy and aborts after a bounded wait.
module mem_wait_fsm
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dmem_req,
  input  logic dmem_ready,
  output logic freeze,
  output logic mem_err
);

  localparam int WW = $clog2(TIMEOUT + 1);

  memState_t      state;
  memState_t      stateNext;
  logic [WW-1:0]  waitCnt;
  logic [WW-1:0]  waitCntNext;
  logic           memErr;
  logic           memErrNext;
  logic           timeoutHit;

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MEM_IDLE;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      memErr  <= memErrNext;
    end
  end

  // Next state and Mealy freeze
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    memErrNext  = memErr;
    freeze      = 1'b0;
    timeoutHit  = (state == MEM_WAIT) &&
                  (waitCnt == WW'(TIMEOUT - 1));
    unique case (state)
      MEM_IDLE: begin
        if (dmem_req && !dmem_ready) begin
          stateNext   = MEM_WAIT;
          waitCntNext = WW'(1);
          freeze      = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          stateNext   = MEM_IDLE;
          waitCntNext = '0;
        end else if (timeoutHit) begin
          stateNext   = MEM_IDLE;
          waitCntNext = '0;
          memErrNext  = 1'b1;
        end else begin
          waitCntNext = waitCnt + WW'(1);
          freeze      = 1'b1;
        end
      end
      default: begin
        stateNext   = MEM_IDLE;
        waitCntNext = '0;
      end
    endcase
  end

  assign mem_err = memErr;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall,
// control flush, memory freeze and perf counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic freeze;
  logic lwStall;
  logic frz;
  logic redirect;
  logic loadHold;

  mem_wait_fsm #(
    .TIMEOUT (TIMEOUT)
  ) uMemWait (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .freeze     (freeze),
    .mem_err    (mem_err)
  );

  // Load in E feeding a source of the instruction in D
  always_comb begin
    lwStall = (ResultSrcE == RESULT_LOAD) &&
              (RdE != 5'd0) &&
              ((RdE == Rs1D) || (RdE == Rs2D));
  end

  // Exclusive control cases: freeze > redirect > load-use
  always_comb begin
    frz      = rst_n && freeze;
    redirect = rst_n && !freeze && PCSrcE;
    loadHold = rst_n && !freeze && !PCSrcE && lwStall;
  end

  // Forward selects and stage stall/flush controls
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (rst_n) begin
      ForwardAE = fwdSel(Rs1E, RdM, RegWriteM,
                         RdW, RegWriteW);
      ForwardBE = fwdSel(Rs2E, RdM, RegWriteM,
                         RdW, RegWriteW);
    end
    unique case (1'b1)
      !rst_n: begin
      end
      frz: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b1;
      end
      redirect: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b0;
      end
      loadHold: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b1;
        FlushW = 1'b0;
      end
      default: begin
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
      end
    endcase
  end

  // Stall and redirect performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze || (lwStall && !PCSrcE))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (PCSrcE && !freeze)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0]  RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, dmem_req, dmem_ready;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checks;
  int failures;

  // model state
  int          runLen;
  logic        mErr;
  logic [31:0] mStall;
  logic [31:0] mFlush;

  logic [12:0] dutVec;
  assign dutVec = {ForwardAE, ForwardBE,
                   StallF, StallD, StallE, StallM,
                   FlushD, FlushE, FlushW, mem_err};

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .FlushW(FlushW), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] mFwd(input logic [4:0] rs);
    logic [4:0] rd [2];
    logic       wr [2];
    rd[0] = RdM; wr[0] = RegWriteM;
    rd[1] = RdW; wr[1] = RegWriteW;
    for (int k = 0; k < 2; k++)
      if (wr[k] && rd[k] != 0 && rd[k] == rs)
        return (k == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit mLw();
    return ResultSrcE == 2'b01 && RdE != 0 &&
           (RdE == Rs1D || RdE == Rs2D);
  endfunction

  // an access is outstanding if we already waited or M asks
  function automatic bit mFrz();
    bit pend;
    pend = (runLen > 0) || dmem_req;
    return pend && !dmem_ready && runLen < TO - 1;
  endfunction

  function automatic logic [12:0] mOut();
    bit lw, pc, f;
    logic [1:0] fa, fb;
    lw = mLw(); pc = PCSrcE; f = mFrz();
    fa = mFwd(Rs1E); fb = mFwd(Rs2E);
    if (!rst_n)
      return {4'b0, 4'b0, 3'b111, 1'b0};
    if (f)
      return {fa, fb, 4'b1111, 3'b001, mErr};
    return {fa, fb, lw && !pc, lw && !pc, 2'b00,
            pc, lw || pc, 1'b0, mErr};
  endfunction

  task automatic mReset();
    runLen = 0; mErr = 1'b0;
    mStall = 0; mFlush = 0;
  endtask

  task automatic mTick();
    bit pend;
    if (!rst_n) begin
      mReset();
      return;
    end
    if (mFrz() || (mLw() && !PCSrcE)) mStall++;
    if (PCSrcE && !mFrz()) mFlush++;
    pend = (runLen > 0) || dmem_req;
    if (pend && !dmem_ready) begin
      if (runLen == TO - 1) begin
        mErr = 1'b1;
        runLen = 0;
      end else runLen++;
    end else runLen = 0;
  endtask

  task automatic stepClk();
    mTick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE} = '0;
    ResultSrcE = 2'b00;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic randIn();
    Rs1D = 5'($urandom_range(0, 7));
    Rs2D = 5'($urandom_range(0, 7));
    Rs1E = 5'($urandom_range(0, 7));
    Rs2E = 5'($urandom_range(0, 7));
    RdE  = 5'($urandom_range(0, 7));
    RdM  = 5'($urandom_range(0, 7));
    RdW  = 5'($urandom_range(0, 7));
    RegWriteM  = 1'($urandom);
    RegWriteW  = 1'($urandom);
    ResultSrcE = 2'($urandom);
    PCSrcE     = ($urandom_range(0, 3) == 0);
    dmem_req   = 1'($urandom);
    dmem_ready = ($urandom_range(0, 2) == 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    randIn();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    Rs1E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1;
    mReset();
    #2;
    checks++;
    if (dutVec !== 13'b0000_0000_111_0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=%b",
               dutVec, 13'b0000_0000_111_0);
    end
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
               stall_cnt, flush_cnt);
    end
    repeat (2) stepClk();
    rst_n = 1'b1;
    clearIn();
    #1;
    stepClk();
  endtask

  task automatic test_forward();
    clearIn();
    Rs1E = 5'd5; Rs2E = 5'd5;
    RdM = 5'd5; RegWriteM = 1'b1;
    RdW = 5'd5; RegWriteW = 1'b1;
    #1;
    checks++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
      failures++;
      $display("FAIL fwd_m got=%b/%b exp=10/10",
               ForwardAE, ForwardBE);
    end
    RegWriteM = 1'b0;
    #1;
    checks++;
    if (ForwardAE !== 2'b01) begin
      failures++;
      $display("FAIL fwd_w got=%b exp=01", ForwardAE);
    end
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
    #1;
    checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      failures++;
      $display("FAIL fwd_x0 got=%b/%b exp=00/00",
               ForwardAE, ForwardBE);
    end
    clearIn();
    stepClk();
  endtask

  task automatic test_load_use();
    logic [31:0] s0, f0;
    clearIn();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      failures++;
      $display("FAIL lw_stall got=%b exp=1101",
               {StallF, StallD, FlushD, FlushE});
    end
    s0 = stall_cnt;
    stepClk();
    checks++;
    if (stall_cnt !== s0 + 1) begin
      failures++;
      $display("FAIL lw_cnt got=%0d exp=%0d",
               stall_cnt, s0 + 1);
    end
    PCSrcE = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      failures++;
      $display("FAIL lw_pc got=%b exp=0011",
               {StallF, StallD, FlushD, FlushE});
    end
    s0 = stall_cnt; f0 = flush_cnt;
    stepClk();
    checks++;
    if (flush_cnt !== f0 + 1 || stall_cnt !== s0) begin
      failures++;
      $display("FAIL lw_pc_cnt got=%0d/%0d exp=%0d/%0d",
               flush_cnt, stall_cnt, f0 + 1, s0);
    end
    clearIn();
    stepClk();
  endtask

  task automatic test_mem_wait();
    logic [31:0] s0;
    clearIn();
    dmem_req = 1'b1;
    s0 = stall_cnt;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({StallF, StallD, StallE, StallM, FlushW,
           FlushD, FlushE} !== 7'b1111100) begin
        failures++;
        $display("FAIL wait_frz cyc=%0d got=%b exp=1111100",
                 c, {StallF, StallD, StallE, StallM,
                     FlushW, FlushD, FlushE});
      end
      stepClk();
    end
    dmem_ready = 1'b1;
    #1;
    checks++;
    if ({StallF, StallE, StallM, FlushW} !== 4'b0000) begin
      failures++;
      $display("FAIL wait_release got=%b exp=0000",
               {StallF, StallE, StallM, FlushW});
    end
    stepClk();
    checks++;
    if (stall_cnt !== s0 + 3) begin
      failures++;
      $display("FAIL wait_cnt got=%0d exp=%0d",
               stall_cnt, s0 + 3);
    end
    checks++;
    if (StallM !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle got=%b exp=0", StallM);
    end
    clearIn();
    stepClk();
  endtask

  task automatic test_timeout();
    clearIn();
    dmem_req = 1'b1;
    #1;
    for (int c = 0; c < TO - 1; c++) begin
      checks++;
      if (StallM !== 1'b1 || FlushW !== 1'b1) begin
        failures++;
        $display("FAIL to_frz cyc=%0d got=%b%b exp=11",
                 c, StallM, FlushW);
      end
      stepClk();
    end
    checks++;
    if (StallF !== 1'b0 || FlushW !== 1'b0 ||
        mem_err !== 1'b0) begin
      failures++;
      $display("FAIL to_abort got=%b%b%b exp=000",
               StallF, FlushW, mem_err);
    end
    stepClk();
    dmem_req = 1'b0;
    #1;
    checks++;
    if (mem_err !== 1'b1) begin
      failures++;
      $display("FAIL to_err got=%b exp=1", mem_err);
    end
    stepClk();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    stepClk();
    clearIn();
    stepClk();
    checks++;
    if (mem_err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky got=%b exp=1", mem_err);
    end
  endtask

  task automatic test_reset_midwait();
    clearIn();
    dmem_req = 1'b1;
    stepClk();
    checks++;
    if (StallF !== 1'b1) begin
      failures++;
      $display("FAIL mid_frz got=%b exp=1", StallF);
    end
    rst_n = 1'b0;
    mReset();
    #1;
    checks++;
    if ({StallF, StallD, StallE, StallM, FlushD, FlushE,
         FlushW, mem_err} !== 8'b0000_1110) begin
      failures++;
      $display("FAIL mid_rst got=%b exp=00001110",
               {StallF, StallD, StallE, StallM,
                FlushD, FlushE, FlushW, mem_err});
    end
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      failures++;
      $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0",
               stall_cnt, flush_cnt);
    end
    stepClk();
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (StallF !== 1'b0 || FlushW !== 1'b0) begin
      failures++;
      $display("FAIL mid_after got=%b%b exp=00",
               StallF, FlushW);
    end
    stepClk();
    clearIn();
    stepClk();
  endtask

  task automatic test_random();
    logic [12:0] exp;
    for (int n = 0; n < 400; n++) begin
      randIn();
      #1;
      exp = mOut();
      checks++;
      if (dutVec !== exp) begin
        failures++;
        $display("FAIL rnd_out n=%0d got=%b exp=%b",
                 n, dutVec, exp);
      end
      checks++;
      if (stall_cnt !== mStall || flush_cnt !== mFlush) begin
        failures++;
        $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d",
                 n, stall_cnt, flush_cnt, mStall, mFlush);
      end
      stepClk();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clearIn();
    mReset();
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_midwait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
